// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared types and constants for the SNN inference sequencer:
//               FSM state encoding, default dimensions and the saturating
//               spike-count increment.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int c_n_out_default  = 10;
    localparam int c_step_w_default = 8;
    localparam int c_cnt_w_default  = 8;
    localparam int c_cls_w_default  = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_STEP  = 3'd2,
        S_WAIT  = 3'd3,
        S_SCAN  = 3'd4,
        S_DONE  = 3'd5
    } snn_state_t;

    // Increment by one when enabled, but never past max_value (no wrap).
    function automatic int unsigned sat_inc(input int unsigned value,
                                            input logic        en,
                                            input int unsigned max_value);
        if (en && (value < max_value)) begin
            return value + 1;
        end
        return value;
    endfunction

endpackage : snn_pkg
`default_nettype wire

// File: rtl/snn_argmax_scan.sv
`default_nettype none
// ============================================================================
// Module      : snn_argmax_scan
// Description : Sequential argmax. One (idx, value) pair per valid cycle;
//               start marks the first element and reloads the running best.
//               Strict '>' keeps the lowest index on ties. best_* include the
//               element presented this cycle, so on the last element they
//               already carry the final answer.
// Revision    : 1.0 - initial release
// ============================================================================
module snn_argmax_scan #(
    parameter int IDX_W = 4,
    parameter int VAL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic             last,
    input  logic [IDX_W-1:0] idx,
    input  logic [VAL_W-1:0] value,
    output logic [IDX_W-1:0] best_idx,
    output logic [VAL_W-1:0] best_val,
    output logic             scan_done
);

    logic [IDX_W-1:0] r_best_idx;
    logic [VAL_W-1:0] r_best_val;
    logic             w_take;

    // First element always wins; later ones only when strictly larger.
    always_comb begin
        w_take   = valid && (start || (value > r_best_val));
        best_idx = w_take ? idx   : r_best_idx;
        best_val = w_take ? value : r_best_val;
    end

    assign scan_done = valid && last;

    // Running best, carried from one scanned element to the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (valid) begin
            r_best_idx <= best_idx;
            r_best_val <= best_val;
        end
    end

endmodule : snn_argmax_scan
`default_nettype wire

// File: rtl/snn_inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : snn_inference_sequencer
// Description : Runs one SNN inference: clears the core, issues one step per
//               time step, accumulates saturating per-class spike counts and
//               selects the winning class with a sequential argmax.
// Revision    : 1.0 - initial release
// ============================================================================
module snn_inference_sequencer
    import snn_pkg::*;
#(
    parameter int N_OUT  = c_n_out_default,
    parameter int STEP_W = c_step_w_default,
    parameter int CNT_W  = c_cnt_w_default,
    parameter int CLS_W  = c_cls_w_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] num_steps,
    output logic              busy,
    output logic              done,
    output logic              core_clear,
    output logic              core_step,
    input  logic              core_step_done,
    input  logic [N_OUT-1:0]  core_spikes,
    output logic [CLS_W-1:0]  result_class,
    output logic [CNT_W-1:0]  result_count,
    input  logic [CLS_W-1:0]  cnt_rd_idx,
    output logic [CNT_W-1:0]  cnt_rd_data
);

    localparam int unsigned c_cnt_max  = (1 << CNT_W) - 1;
    localparam logic [CLS_W-1:0] c_last_cls = CLS_W'(N_OUT - 1);

    snn_state_t        r_state;
    logic [STEP_W-1:0] r_num_steps;
    logic [STEP_W-1:0] r_step_cnt;
    logic [CNT_W-1:0]  r_count [N_OUT];
    logic [CLS_W-1:0]  r_scan_idx;
    logic              r_done;
    logic              r_core_clear;
    logic              r_core_step;
    logic [CLS_W-1:0]  r_result_class;
    logic [CNT_W-1:0]  r_result_count;
    logic [CNT_W-1:0]  r_rd_data;

    logic [STEP_W-1:0] w_step_next;
    logic [CNT_W-1:0]  w_rd_data;
    logic [CNT_W-1:0]  w_scan_val;
    logic              w_scan_valid;
    logic              w_scan_first;
    logic [CLS_W-1:0]  w_best_idx;
    logic [CNT_W-1:0]  w_best_val;
    logic              w_scan_done;

    assign w_step_next  = r_step_cnt + 1'b1;
    assign w_scan_valid = (r_state == S_SCAN);
    assign w_scan_first = w_scan_valid && (r_scan_idx == '0);

    // Counter muxes for the host read port and the scanner; out-of-range reads give 0.
    always_comb begin
        w_rd_data  = '0;
        w_scan_val = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (cnt_rd_idx == CLS_W'(i)) w_rd_data  = r_count[i];
            if (r_scan_idx == CLS_W'(i)) w_scan_val = r_count[i];
        end
    end

    snn_argmax_scan #(
        .IDX_W (CLS_W),
        .VAL_W (CNT_W)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .start     (w_scan_first),
        .valid     (w_scan_valid),
        .last      (r_scan_idx == c_last_cls),
        .idx       (r_scan_idx),
        .value     (w_scan_val),
        .best_idx  (w_best_idx),
        .best_val  (w_best_val),
        .scan_done (w_scan_done)
    );

    // Sequencer FSM with registered pulse outputs, counters and result latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_num_steps    <= '0;
            r_step_cnt     <= '0;
            r_scan_idx     <= '0;
            r_done         <= 1'b0;
            r_core_clear   <= 1'b0;
            r_core_step    <= 1'b0;
            r_result_class <= '0;
            r_result_count <= '0;
            r_rd_data      <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            r_done       <= 1'b0;
            r_core_clear <= 1'b0;
            r_core_step  <= 1'b0;
            r_rd_data    <= w_rd_data;
            case (r_state)
                S_IDLE: begin
                    // Abort beats a simultaneous start.
                    if (start && !abort) begin
                        r_num_steps  <= num_steps;
                        r_step_cnt   <= '0;
                        r_core_clear <= 1'b1;
                        r_state      <= S_CLEAR;
                        for (int i = 0; i < N_OUT; i++) begin
                            r_count[i] <= '0;
                        end
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_num_steps == '0) begin
                        r_scan_idx <= '0;
                        r_state    <= S_SCAN;
                    end else begin
                        r_core_step <= 1'b1;
                        r_state     <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_state <= abort ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (core_step_done) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            r_count[i] <= CNT_W'(sat_inc(32'(r_count[i]), core_spikes[i], c_cnt_max));
                        end
                        r_step_cnt <= w_step_next;
                        if (w_step_next == r_num_steps) begin
                            r_scan_idx <= '0;
                            r_state    <= S_SCAN;
                        end else begin
                            r_core_step <= 1'b1;
                            r_state     <= S_STEP;
                        end
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_scan_done) begin
                        r_result_class <= w_best_idx;
                        r_result_count <= w_best_val;
                        r_done         <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign core_clear   = r_core_clear;
    assign core_step    = r_core_step;
    assign result_class = r_result_class;
    assign result_count = r_result_count;
    assign cnt_rd_data  = r_rd_data;

endmodule : snn_inference_sequencer
`default_nettype wire
